stl_credit_rx: RTL
==================

Name: stl_credit_rx

Overview:
- Receiver end of a credit-based point-to-point link.
- Upstream side: valid/data only, no ready. The sender may transmit only while it holds credits. This block returns one credit per freed buffer entry on a single-bit `crd_o` pulse.
- Buffers up to DEPTH beats and presents them downstream on a standard valid/ready interface, so it can feed a StlPipe slice.
- Sits at the far end of long or registered links where a combinational ready path cannot be closed.

Parameters:
- DATA_W, 10, payload width in bits.
- DEPTH, 4, buffer entries and initial credit count; legal range 2..64.
- CNT_W, $clog2(DEPTH+1), derived width of all counters; do not override.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- upvld_i  input  1  beat valid from credit sender; one beat per asserted cycle.
- updat_i  input  DATA_W  beat payload, sampled when upvld_i=1.
- crd_o  output  1  registered credit-return pulse; each cycle high returns one credit.
- dnvld_o  output  1  head entry valid.
- dnrdy_i  input  1  downstream ready.
- dndat_o  output  DATA_W  head entry payload, driven from storage flops.
- level_o  output  CNT_W  current occupancy, 0..DEPTH.
- init_done_o  output  1  high once all DEPTH initial credits have been issued.
- ovf_o  output  1  sticky protocol-violation flag: beat arrived while full.

Behaviour:
- Reset, synchronous: dnvld_o=0, crd_o=0, level_o=0, init_done_o=0, ovf_o=0. Read/write pointers=0. Owed-credit counter crd_cnt=DEPTH. State=INIT.
- pop = dnvld_o && dnrdy_i.
- push = upvld_i && (level<DEPTH || pop).
- Push when full with a simultaneous pop is legal: the entry frees and refills in the same cycle.
- Storage:
  - Circular buffer, pointers wrap DEPTH-1 to 0. Non-power-of-2 DEPTH must wrap correctly.
  - level updates +1 on push only, -1 on pop only, unchanged on both or neither.
  - dnvld_o = (level!=0).
  - Beat pushed at edge t appears on dnvld_o/dndat_o in cycle t+1; no combinational upvld_i to dnvld_o path.
- Overflow:
  - upvld_i && level==DEPTH && !pop: beat dropped, storage and pointers unchanged.
  - ovf_o set and held until rst.
- Credit return, uniform for init and run:
  - owed = crd_cnt + pop.
  - crd_o <= (owed!=0).
  - crd_cnt <= owed - (owed!=0).
  - At most one credit per cycle; excess stays in backlog. crd_cnt never exceeds DEPTH.
  - A pop at edge t with empty backlog gives crd_o=1 in cycle t+1.
- FSM INIT/RUN:
  - INIT counts crd_o pulses issued since reset.
  - On the DEPTH-th pulse, go to RUN; init_done_o=1 from the next cycle onward.
  - Pushes and pops are fully functional during INIT because the sender may use early credits.
- Conservation invariant: level + crd_cnt + crd_o ≤ DEPTH on every cycle. Assert it in the bench.
- Reset mid-operation: buffered data is discarded, backlog is reloaded to DEPTH, and the init sequence restarts. The sender must reset concurrently.
- dndat_o is stable while dnvld_o=1 and dnrdy_i=0.

Decomposition:
- Package stl_credit_pkg:
  - enum `crd_state_e` {INIT, RUN}.
  - Function clog2 for CNT_W.
  - Constant CRD_MAX_DEPTH=64.
- Sub-module stl_credit_buf: storage array, pointers and level, with push/pop in and head/level out.
- Top holds the credit counter, FSM and overflow flag.

Test Plan:
- Reset, then idle with DEPTH=4: crd_o=1 exactly on cycles 1..4 after rst falls, then 0; init_done_o=1 from cycle 5; level_o=0.
- Push 0x001..0x004 back-to-back with dnrdy_i=0: level_o=4, dndat_o=0x001 held, no crd_o in RUN. Raise dnrdy_i: pops 0x001..0x004 in order, crd_o high 4 consecutive cycles, each lagging its pop by 1.
- Full with pop and push in the same cycle (push 0x3FF): level_o stays 4, 0x3FF is the last popped, no ovf_o.
- Push while full with dnrdy_i=0: ovf_o=1 and stays 1, level_o=4, stored data unchanged.
- Push/pop during INIT (sender uses credit 1 at cycle 2, dnrdy_i=1): crd_o stays high cycles 1..5 (4 init + 1 returned), init_done_o from cycle 5.
- Random traffic with a credit-model sender, DEPTH=3 and 5: data order preserved, invariant never violated, ovf_o stays 0. Assert rst mid-stream: all outputs match reset values at the next cycle.

Source files
------------

// File: rtl/stl_credit_pkg.sv
// Shared types and helpers for the credit-based link receiver.
// Holds the FSM state encoding and counter sizing function.
package stl_credit_pkg;

  localparam int CRD_MAX_DEPTH = 64;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } crd_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stl_credit_buf.sv
// Circular beat buffer for the credit receiver.
// Pointers wrap at DEPTH-1, so any DEPTH (not just powers of 2) works.
module stl_credit_buf
  import stl_credit_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_dat,
  output logic [DATA_W-1:0] o_head,
  output logic [CNT_W-1:0]  o_level,
  output logic              o_vld
);

  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_level;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wptr <= nxt(r_wptr);
      if (i_pop)  r_rptr <= nxt(r_rptr);
      unique case ({i_push, i_pop})
        2'b10:   r_level <= r_level + CNT_W'(1);
        2'b01:   r_level <= r_level - CNT_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_level = r_level;
  assign o_vld   = (r_level != '0);

endmodule

// File: rtl/stl_credit_rx.sv
// Receiver end of a credit-based link: buffers beats and
// returns one credit per freed entry, one pulse per cycle.
module stl_credit_rx
  import stl_credit_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upvld_i,
  input  logic [DATA_W-1:0] updat_i,
  output logic              crd_o,
  output logic              dnvld_o,
  input  logic              dnrdy_i,
  output logic [DATA_W-1:0] dndat_o,
  output logic [CNT_W-1:0]  level_o,
  output logic              init_done_o,
  output logic              ovf_o
);

  crd_state_e       r_state;
  crd_state_e       w_state_nx;
  logic [CNT_W-1:0] r_init_cnt;
  logic [CNT_W-1:0] w_init_nx;
  logic [CNT_W-1:0] r_crd_cnt;
  logic             r_crd;
  logic             r_ovf;
  logic [CNT_W:0]   w_owed;
  logic             w_owe;
  logic             w_pop;
  logic             w_push;
  logic             w_full;

  assign w_full = (level_o == CNT_W'(DEPTH));
  assign w_pop  = dnvld_o && dnrdy_i;
  assign w_push = upvld_i && (!w_full || w_pop);

  stl_credit_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (updat_i),
    .o_head  (dndat_o),
    .o_level (level_o),
    .o_vld   (dnvld_o)
  );

  // Initial credits and returned credits share one backlog.
  assign w_owed = {1'b0, r_crd_cnt} + (CNT_W + 1)'(w_pop);
  assign w_owe  = (w_owed != '0);

  always_comb begin
    w_state_nx = r_state;
    w_init_nx  = r_init_cnt;
    unique case (r_state)
      INIT: begin
        if (r_crd) begin
          if (r_init_cnt == CNT_W'(DEPTH - 1)) begin
            w_state_nx = RUN;
          end else begin
            w_init_nx = r_init_cnt + CNT_W'(1);
          end
        end
      end
      RUN: w_state_nx = RUN;
      default: w_state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      r_crd_cnt  <= CNT_W'(DEPTH);
      r_crd      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_init_cnt <= w_init_nx;
      r_crd      <= w_owe;
      r_crd_cnt  <= CNT_W'(w_owed - (CNT_W + 1)'(w_owe));
      if (upvld_i && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign crd_o       = r_crd;
  assign init_done_o = (r_state == RUN);
  assign ovf_o       = r_ovf;

endmodule
